// File: rtl/operand_fetch.sv
// operand_fetch: scoreboarded operand-read stage between decode and execute.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   in_*                  : decoded instruction offer (valid/ready handshake)
//   readAdd1/2, rf_out1/2 : combinational register-file read port
//   wb_valid/wb_add/wb_data : writeback completing this cycle
//   out_*                 : registered operand bundle (valid/ready handshake)
//   `define OPERAND_FETCH_BYPASS_EN forwards same-cycle writeback data to sources.
module operand_fetch #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sr1,
  input  logic [2:0]       in_sr2,
  input  logic [2:0]       in_dr,
  input  logic             in_use_sr1,
  input  logic             in_use_sr2,
  input  logic             in_writes_dr,
  output logic [2:0]       readAdd1,
  output logic [2:0]       readAdd2,
  input  logic [WIDTH-1:0] rf_out1,
  input  logic [WIDTH-1:0] rf_out2,
  input  logic             wb_valid,
  input  logic [2:0]       wb_add,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_op1,
  output logic [WIDTH-1:0] out_op2,
  output logic [2:0]       out_dr,
  output logic             out_writes_dr
);
  logic [7:0]       busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic             out_writes_dr_q, out_writes_dr_d;
  logic [WIDTH-1:0] out_op1_q, out_op1_d, out_op2_q, out_op2_d;
  logic [2:0]       out_dr_q, out_dr_d;
  logic             byp1, byp2, hazard, accept;
  assign readAdd1      = in_sr1;
  assign readAdd2      = in_sr2;
  assign out_valid     = out_valid_q;
  assign out_writes_dr = out_writes_dr_q;
  assign out_op1       = out_op1_q;
  assign out_op2       = out_op2_q;
  assign out_dr        = out_dr_q;
  always_comb begin
`ifdef OPERAND_FETCH_BYPASS_EN
    byp1 = wb_valid && (wb_add == in_sr1);
    byp2 = wb_valid && (wb_add == in_sr2);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    // Destination hazard is never bypassed: a pending write must retire first (WAW).
    hazard = (in_use_sr1 && busy_q[in_sr1] && !byp1)
           | (in_use_sr2 && busy_q[in_sr2] && !byp2)
           | (in_writes_dr && busy_q[in_dr]);
    in_ready = !hazard && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_add] = 1'b0;
    if (accept && in_writes_dr) busy_d[in_dr] = 1'b1;
    out_valid_d     = accept || (out_valid_q && !out_ready);
    out_op1_d       = accept ? ((in_use_sr1 && byp1) ? wb_data : rf_out1) : out_op1_q;
    out_op2_d       = accept ? ((in_use_sr2 && byp2) ? wb_data : rf_out2) : out_op2_q;
    out_dr_d        = accept ? in_dr : out_dr_q;
    out_writes_dr_d = accept ? in_writes_dr : out_writes_dr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q          <= '0;
      out_valid_q     <= 1'b0;
      out_writes_dr_q <= 1'b0;
      out_op1_q       <= '0;
      out_op2_q       <= '0;
      out_dr_q        <= '0;
    end else begin
      busy_q          <= busy_d;
      out_valid_q     <= out_valid_d;
      out_writes_dr_q <= out_writes_dr_d;
      out_op1_q       <= out_op1_d;
      out_op2_q       <= out_op2_d;
      out_dr_q        <= out_dr_d;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and random checks of operand_fetch against a queue-based model.
module tb_operand_fetch;
  localparam int W = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, in_valid, in_use_sr1, in_use_sr2, in_writes_dr, wb_valid, out_ready;
  logic [2:0] in_sr1, in_sr2, in_dr, wb_add;
  logic [W-1:0] wb_data;
  logic in_ready, out_valid, out_writes_dr;
  logic [2:0] readAdd1, readAdd2, out_dr;
  logic [W-1:0] rf_out1, rf_out2, out_op1, out_op2;
  logic [W-1:0] rf [8];
  assign rf_out1 = rf[readAdd1];
  assign rf_out2 = rf[readAdd2];
  operand_fetch #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr),
    .in_use_sr1(in_use_sr1), .in_use_sr2(in_use_sr2), .in_writes_dr(in_writes_dr),
    .readAdd1(readAdd1), .readAdd2(readAdd2), .rf_out1(rf_out1), .rf_out2(rf_out2),
    .wb_valid(wb_valid), .wb_add(wb_add), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_dr(out_dr), .out_writes_dr(out_writes_dr)
  );
  int checks = 0, failures = 0;
  logic [2:0] inflight [$];
  logic ev, ewd;
  logic [W-1:0] e1, e2;
  logic [2:0] edr;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit is_busy(input logic [2:0] r);
    foreach (inflight[i]) if (inflight[i] == r) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit byp(input logic [2:0] r);
`ifdef OPERAND_FETCH_BYPASS_EN
    return wb_valid && wb_add == r;
`else
    return 1'b0;
`endif
  endfunction
  task automatic cyc();
    bit haz, rdy, acc;
    logic [W-1:0] v1, v2;
    #1;
    haz = (in_use_sr1 && is_busy(in_sr1) && !byp(in_sr1))
       || (in_use_sr2 && is_busy(in_sr2) && !byp(in_sr2))
       || (in_writes_dr && is_busy(in_dr));
    rdy = !haz && (!ev || out_ready);
    chk("in_ready", in_ready, rdy);
    chk("readAdd1", readAdd1, in_sr1);
    chk("readAdd2", readAdd2, in_sr2);
    acc = in_valid && rdy;
    v1 = (in_use_sr1 && byp(in_sr1)) ? wb_data : rf[in_sr1];
    v2 = (in_use_sr2 && byp(in_sr2)) ? wb_data : rf[in_sr2];
    @(posedge clk);
    #1;
    if (wb_valid) begin
      rf[wb_add] = wb_data;
      for (int i = inflight.size() - 1; i >= 0; i--) if (inflight[i] == wb_add) inflight.delete(i);
    end
    if (reset) begin
      inflight.delete();
      ev = 0; e1 = '0; e2 = '0; edr = '0; ewd = 0;
    end else if (acc) begin
      ev = 1; e1 = v1; e2 = v2; edr = in_dr; ewd = in_writes_dr;
      if (in_writes_dr) inflight.push_back(in_dr);
    end else if (ev && out_ready) ev = 0;
    chk("out_valid", out_valid, ev);
    chk("out_op1", out_op1, e1);
    chk("out_op2", out_op2, e2);
    chk("out_dr", out_dr, edr);
    chk("out_writes_dr", out_writes_dr, ewd);
  endtask
  task automatic idle();
    reset = 0; in_valid = 0; in_use_sr1 = 0; in_use_sr2 = 0; in_writes_dr = 0;
    in_sr1 = 0; in_sr2 = 0; in_dr = 0; wb_valid = 0; wb_add = 0; wb_data = 0; out_ready = 1;
  endtask
  task automatic issue(input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                       input bit u1, input bit u2, input bit wd);
    in_valid = 1; in_sr1 = s1; in_sr2 = s2; in_dr = d;
    in_use_sr1 = u1; in_use_sr2 = u2; in_writes_dr = wd;
  endtask
  task automatic wb(input logic [2:0] a, input logic [W-1:0] d);
    wb_valid = 1; wb_add = a; wb_data = d;
  endtask
  initial begin
    foreach (rf[i]) rf[i] = W'($urandom);
    rf[2] = 16'h1234;
    rf[3] = 16'h00FF;
    idle();
    reset = 1;
    @(posedge clk);
    #1;
    inflight.delete();
    ev = 0; e1 = '0; e2 = '0; edr = '0; ewd = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_op1", out_op1, 0);
    chk("rst_out_dr", out_dr, 0);
    chk("rst_in_ready", in_ready, 1);
    idle();
    issue(2, 3, 0, 1, 1, 0);
    cyc();
    chk("basic_op1", out_op1, 16'h1234);
    chk("basic_op2", out_op2, 16'h00FF);
    idle(); cyc();
    issue(1, 1, 5, 0, 0, 1); cyc();
    issue(5, 0, 0, 1, 0, 0); cyc(); cyc();
    wb(5, 16'hBEEF); cyc();
    wb_valid = 0; cyc();
    chk("raw_op1", out_op1, 16'hBEEF);
    idle(); cyc();
    issue(2, 3, 7, 1, 1, 0); cyc();
    out_ready = 0;
    issue(3, 2, 6, 1, 1, 0); cyc(); cyc(); cyc();
    chk("stall_op1", out_op1, 16'h1234);
    out_ready = 1; cyc();
    chk("release_op1", out_op1, 16'h00FF);
    idle(); cyc();
    issue(0, 0, 4, 0, 0, 1); wb(4, 16'h4444); cyc();
    wb_valid = 0; issue(4, 0, 0, 1, 0, 0); cyc(); cyc();
    chk("setwins_ready", in_ready, 0);
    wb(4, 16'h5555); cyc();
    wb_valid = 0; cyc();
    idle();
    issue(0, 0, 6, 0, 0, 1); cyc(); cyc(); cyc();
    wb(6, 16'h6666); cyc();
    wb_valid = 0; cyc();
    idle(); wb(6, 16'h6767); cyc();
    idle();
    issue(0, 0, 1, 0, 0, 1); cyc();
    idle(); out_ready = 0; reset = 1; cyc();
    reset = 0; out_ready = 1;
    issue(1, 0, 0, 1, 0, 0); cyc();
    chk("post_reset_accept", out_valid, 1);
    idle(); cyc();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom % 97) == 0;
      in_valid = $urandom % 4 != 0;
      in_sr1 = 3'($urandom); in_sr2 = 3'($urandom); in_dr = 3'($urandom);
      in_use_sr1 = $urandom % 2 == 1; in_use_sr2 = $urandom % 2 == 1;
      in_writes_dr = $urandom % 3 != 0;
      out_ready = $urandom % 4 != 0;
      wb_valid = 0; wb_add = 3'($urandom); wb_data = W'($urandom);
      if (inflight.size() > 0 && $urandom % 3 == 0) begin
        wb_valid = 1;
        wb_add = inflight[$urandom_range(0, inflight.size() - 1)];
      end else if ($urandom % 10 == 0) wb_valid = 1;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
